// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: PS/2 scan-code decoder (E0/F0 prefixes) feeding a first-word fall-through event FIFO.
// Optional macro PS2_PAUSE_FILTER_EN collapses the 8-byte Pause sequence into one event.
`default_nettype none

module ps2_key_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CODE_VALID,
  input  logic [7:0] CODE,
  input  logic       CODE_ERR,
  output logic       EVT_VALID,
  output logic [9:0] EVT_DATA,
  input  logic       EVT_READY,
  output logic       OVERFLOW,
  output logic [7:0] ERR_COUNT,
  input  logic       CLR_STATUS
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT_CYC - 1);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_EXT     = 3'd1;
  localparam logic [2:0] c_BRK     = 3'd2;
  localparam logic [2:0] c_EXT_BRK = 3'd3;
`ifdef PS2_PAUSE_FILTER_EN
  localparam logic [2:0] c_PAUSE   = 3'd4;
  logic [2:0] r_pause_cnt;
`endif

  logic [2:0]      r_state, w_nxt_state;
  logic [c_TW-1:0] r_tmo_cnt;
  logic            w_timeout, w_push, w_err_inc;
  logic [9:0]      w_push_data;

  logic [9:0]      r_mem [FIFO_DEPTH];
  logic [c_AW:0]   r_wr_ptr, r_rd_ptr;
  logic            w_full, w_empty, w_pop, w_wr_en, w_drop;
  logic            r_overflow;
  logic [7:0]      r_err_cnt;

  assign w_timeout = (r_state != c_IDLE) && !CODE_VALID && (r_tmo_cnt == c_TMO_LAST);

  always_comb begin
    w_nxt_state = r_state;
    w_push      = 1'b0;
    w_push_data = '0;
    w_err_inc   = 1'b0;
    if (w_timeout) begin
      w_nxt_state = c_IDLE;
      w_err_inc   = 1'b1;
    end else if (CODE_VALID) begin
      if (CODE_ERR) begin
        w_nxt_state = c_IDLE;
        w_err_inc   = 1'b1;
      end
`ifdef PS2_PAUSE_FILTER_EN
      else if (r_state == c_PAUSE) begin
        // Payload bytes of the Pause sequence are swallowed unchecked.
        if (r_pause_cnt == 3'd6) begin
          w_push      = 1'b1;
          w_push_data = {2'b01, 8'hE1};
          w_nxt_state = c_IDLE;
        end
      end
`endif
      else if (CODE == 8'h00 || CODE == 8'hFF) begin
        w_nxt_state = c_IDLE;
        w_err_inc   = 1'b1;
      end else begin
        case (r_state)
          c_IDLE: begin
            if (CODE == 8'hE0)      w_nxt_state = c_EXT;
            else if (CODE == 8'hF0) w_nxt_state = c_BRK;
`ifdef PS2_PAUSE_FILTER_EN
            else if (CODE == 8'hE1) w_nxt_state = c_PAUSE;
`endif
            else begin
              w_push      = 1'b1;
              w_push_data = {2'b00, CODE};
            end
          end
          c_EXT: begin
            if (CODE == 8'hF0)      w_nxt_state = c_EXT_BRK;
            else if (CODE == 8'hE0) w_nxt_state = c_EXT;
            else begin
              w_push      = 1'b1;
              w_push_data = {2'b01, CODE};
              w_nxt_state = c_IDLE;
            end
          end
          c_BRK, c_EXT_BRK: begin
            w_nxt_state = c_IDLE;
            if (CODE == 8'hE0 || CODE == 8'hF0) begin
              w_err_inc = 1'b1;
            end else begin
              w_push      = 1'b1;
              w_push_data = {1'b1, (r_state == c_EXT_BRK), CODE};
            end
          end
          default: w_nxt_state = c_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state   <= c_IDLE;
      r_tmo_cnt <= '0;
    end else begin
      r_state <= w_nxt_state;
      if (CODE_VALID || r_state == c_IDLE || w_timeout) r_tmo_cnt <= '0;
      else                                             r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

`ifdef PS2_PAUSE_FILTER_EN
  always_ff @(posedge CLK) begin
    if (!RESET_N)                                       r_pause_cnt <= '0;
    else if (r_state != c_PAUSE)                        r_pause_cnt <= '0;
    else if (CODE_VALID && !CODE_ERR)                   r_pause_cnt <= r_pause_cnt + 1'b1;
  end
`endif

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_pop   = !w_empty && EVT_READY;
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge CLK) begin
    if (w_wr_en) r_mem[r_wr_ptr[c_AW-1:0]] <= w_push_data;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      if (CLR_STATUS)  r_overflow <= w_drop;
      else if (w_drop) r_overflow <= 1'b1;
      if (CLR_STATUS)                             r_err_cnt <= {7'd0, w_err_inc};
      else if (w_err_inc && r_err_cnt != 8'hFF)   r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign EVT_VALID = !w_empty;
  assign EVT_DATA  = w_empty ? 10'd0 : r_mem[r_rd_ptr[c_AW-1:0]];
  assign OVERFLOW  = r_overflow;
  assign ERR_COUNT = r_err_cnt;

endmodule

`default_nettype wire

// File: doc/ps2_key_ctrl.md
PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH SHALL be: FIFO_DEPTH, default 8, event FIFO entries (power of two, 2..64).
REQ-002 Parameter TIMEOUT_CYC SHALL be: TIMEOUT_CYC, default 200000, CLK cycles allowed between bytes of one multi-byte sequence.
REQ-003 Port SHALL be: CLK  input  1  board clock; single clock domain.
REQ-004 Port SHALL be: RESET_N  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 Port SHALL be: CODE_VALID  input  1  one-cycle strobe, received byte present.
REQ-006 Port SHALL be: CODE  input  8  received scan-code byte, qualified by CODE_VALID.
REQ-007 Port SHALL be: CODE_ERR  input  1  parity/framing error flag, qualified by CODE_VALID.
REQ-008 Port SHALL be: EVT_VALID  output  1  FIFO non-empty.
REQ-009 Port SHALL be: EVT_DATA  output  10  FIFO head {BREAK, EXT, CODE[7:0]}, first-word fall-through.
REQ-010 Port SHALL be: EVT_READY  input  1  consumer pop request.
REQ-011 Port SHALL be: OVERFLOW  output  1  sticky, event dropped on full FIFO.
REQ-012 Port SHALL be: ERR_COUNT  output  8  saturating error counter.
REQ-013 Port SHALL be: CLR_STATUS  input  1  one-cycle clear of OVERFLOW and ERR_COUNT.

Function
REQ-014 The decoder FSM SHALL have states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), and PAUSE only under PS2_PAUSE_FILTER_EN.
REQ-015 The FSM SHALL act only on cycles with CODE_VALID=1; otherwise it holds state except on timeout.
REQ-016 In IDLE, 8'hE0 SHALL go to EXT, 8'hF0 to BRK, and any other byte SHALL push {0,0,CODE} and stay in IDLE.
REQ-017 In EXT, 8'hF0 SHALL go to EXT_BRK, 8'hE0 SHALL stay in EXT, and any other byte SHALL push {0,1,CODE} and go to IDLE.
REQ-018 In BRK, a byte other than E0/F0 SHALL push {1,0,CODE}; in EXT_BRK it SHALL push {1,1,CODE}; both go to IDLE.
REQ-019 E0 or F0 received in BRK or EXT_BRK SHALL be a protocol violation: no push, go to IDLE, ERR_COUNT increments.
REQ-020 Byte 8'h00 or 8'hFF in any state SHALL be a keyboard error: no push, go to IDLE, ERR_COUNT increments.
REQ-021 CODE_VALID with CODE_ERR=1 SHALL discard the byte, force IDLE and increment ERR_COUNT, regardless of CODE value.
REQ-022 A cycle counter SHALL reset on every CODE_VALID and count while not IDLE; reaching TIMEOUT_CYC SHALL force IDLE with no push and increment ERR_COUNT.
REQ-023 A push SHALL be written on the cycle after the CODE_VALID cycle, making EVT_VALID=1 at that edge at the earliest (1-cycle latency).
REQ-024 A pop SHALL occur when EVT_VALID=1 and EVT_READY=1; EVT_READY SHALL be ignored when the FIFO is empty.
REQ-025 A push into a full FIFO SHALL be dropped and set OVERFLOW; a simultaneous push and pop on a full FIFO SHALL both succeed.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with one extra pointer bit.
REQ-027 ERR_COUNT SHALL saturate at 255 and SHALL never wrap.
REQ-028 CLR_STATUS SHALL clear OVERFLOW and ERR_COUNT; a same-cycle set or increment SHALL win, giving OVERFLOW=1 or ERR_COUNT=1.

Reset
REQ-029 With RESET_N=0 at a CLK edge, the block SHALL go to FSM IDLE, an empty FIFO, timeout counter 0, EVT_VALID=0, EVT_DATA=0, OVERFLOW=0 and ERR_COUNT=0.
REQ-030 Reset asserted mid-sequence or with the FIFO non-empty SHALL discard all partial and queued events, with no residual push after release.

Configuration
REQ-031 With macro PS2_PAUSE_FILTER_EN defined, 8'hE1 in IDLE SHALL enter PAUSE, which swallows exactly 7 further valid bytes and then pushes {0,1,8'hE1} and returns to IDLE.
REQ-032 In PAUSE, CODE_ERR and timeout SHALL abort to IDLE with ERR_COUNT increment, and 00/FF SHALL NOT be checked.
REQ-033 Without PS2_PAUSE_FILTER_EN, there SHALL be no PAUSE state and 8'hE1 SHALL be handled as an ordinary byte per REQ-016/017/018.

Verification
REQ-034 Directed test: bytes 1C, then F0 1C -> events 0x01C and 0x21C in order, each appearing 1 cycle after its final byte.
REQ-035 Directed test: E0 75, E0 F0 75 -> events 0x175 and 0x375; ERR_COUNT stays 0.
REQ-036 Directed test: EVT_READY=0 with FIFO_DEPTH+1 make codes -> FIFO_DEPTH events kept, last dropped, OVERFLOW=1; then CLR_STATUS -> OVERFLOW=0.
REQ-037 Directed test: E0, then TIMEOUT_CYC idle cycles, then 1C -> no extended event, ERR_COUNT=1, event 0x01C.
REQ-038 Directed test: F0 then F0, 00, and a CODE_ERR byte -> no events, ERR_COUNT=3; RESET_N low mid E0 F0 -> FIFO empty, IDLE.
REQ-039 Directed test with PS2_PAUSE_FILTER_EN: E1 14 77 E1 F0 14 F0 77 -> single event 0x1E1; without the macro -> the per-rule events of REQ-033.
